// File: rtl/tlb_op_ctrl.sv
// Sequences LoongArch TLB management ops (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB) onto the TLB ports.
// Define TLB_FILL_LFSR_EN to pick the TLBFILL victim from an 8-bit LFSR instead of a round-robin counter.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vppn,
    input  logic [IDXW-1:0] csr_index,
    input  logic            csr_ne,
    input  logic [5:0]      csr_ps,
    input  logic [18:0]     csr_vppn,
    input  logic [9:0]      csr_asid,
    input  logic            csr_g,
    input  logic [25:0]     csr_elo0,
    input  logic [25:0]     csr_elo1,
    input  logic            csr_tlbr,
    input  logic            lsu_s1_req,
    output logic            s1_sel,
    output logic [18:0]     s1_vppn,
    output logic [9:0]      s1_asid,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_index,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic [88:0]     tlb_w_entry,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic [88:0]     tlb_r_entry,
    output logic            tlb_inv_valid,
    output logic [4:0]      tlb_inv_op,
    output logic            done,
    output logic            res_found,
    output logic [IDXW-1:0] res_index,
    output logic [88:0]     res_entry,
    output logic            res_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRCH,
        S_RD,
        S_WR,
        S_INV,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic            fill_q;
    logic [4:0]      inv_op_q;
    logic [9:0]      inv_asid_q;
    logic [18:0]     inv_vppn_q;
    logic [IDXW-1:0] index_q;
    logic            ne_q;
    logic [5:0]      ps_q;
    logic [18:0]     vppn_q;
    logic [9:0]      asid_q;
    logic            g_q;
    logic [25:0]     elo0_q;
    logic [25:0]     elo1_q;
    logic            tlbr_q;

    logic            accept;
    logic            inv_bad;
    logic [IDXW-1:0] fill_idx;
    logic            fill_step;

    assign accept    = op_valid && (state == S_IDLE);
    assign inv_bad   = (inv_op_q > 5'd6);
    assign fill_step = (state == S_WR) && fill_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CSR and invtlb operands are captured once at acceptance so later CSR writes cannot leak in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_q     <= 1'b0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            index_q    <= '0;
            ne_q       <= 1'b0;
            ps_q       <= '0;
            vppn_q     <= '0;
            asid_q     <= '0;
            g_q        <= 1'b0;
            elo0_q     <= '0;
            elo1_q     <= '0;
            tlbr_q     <= 1'b0;
        end else if (accept) begin
            fill_q     <= (op_code == 3'd3);
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vppn_q <= inv_vppn;
            index_q    <= csr_index;
            ne_q       <= csr_ne;
            ps_q       <= csr_ps;
            vppn_q     <= csr_vppn;
            asid_q     <= csr_asid;
            g_q        <= csr_g;
            elo0_q     <= csr_elo0;
            elo1_q     <= csr_elo1;
            tlbr_q     <= csr_tlbr;
        end
    end

`ifdef TLB_FILL_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 8'h01;
        end else if (fill_step) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign fill_idx = lfsr[IDXW-1:0];
`else
    logic [IDXW-1:0] fill_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_cnt <= '0;
        end else if (fill_step) begin
            if (fill_cnt == IDXW'(TLBNUM - 1)) begin
                fill_cnt <= '0;
            end else begin
                fill_cnt <= fill_cnt + IDXW'(1);
            end
        end
    end

    assign fill_idx = fill_cnt;
`endif

    always_comb begin
        state_nxt     = state;
        op_ready      = 1'b0;
        s1_sel        = 1'b0;
        s1_vppn       = '0;
        s1_asid       = '0;
        tlb_we        = 1'b0;
        tlb_w_index   = '0;
        tlb_w_entry   = '0;
        tlb_r_index   = '0;
        tlb_inv_valid = 1'b0;
        tlb_inv_op    = '0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    case (op_code)
                        3'd0:    state_nxt = S_SRCH;
                        3'd1:    state_nxt = S_RD;
                        3'd2:    state_nxt = S_WR;
                        3'd3:    state_nxt = S_WR;
                        3'd4:    state_nxt = S_INV;
                        default: state_nxt = S_DONE;
                    endcase
                end
            end
            S_SRCH: begin
                if (!lsu_s1_req) begin
                    s1_sel    = 1'b1;
                    s1_vppn   = vppn_q;
                    s1_asid   = asid_q;
                    state_nxt = S_DONE;
                end
            end
            S_RD: begin
                tlb_r_index = index_q;
                state_nxt   = S_DONE;
            end
            S_WR: begin
                tlb_we      = 1'b1;
                tlb_w_index = fill_q ? fill_idx : index_q;
                tlb_w_entry = {tlbr_q | ~ne_q, vppn_q, ps_q, asid_q, g_q, elo0_q, elo1_q};
                state_nxt   = S_DONE;
            end
            S_INV: begin
                if (inv_bad) begin
                    state_nxt = S_DONE;
                end else if (!lsu_s1_req) begin
                    s1_sel        = 1'b1;
                    tlb_inv_valid = 1'b1;
                    s1_vppn       = inv_vppn_q;
                    s1_asid       = inv_asid_q;
                    tlb_inv_op    = inv_op_q;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results update only on the way into DONE; res_err is refreshed by every op.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_found <= 1'b0;
            res_index <= '0;
            res_entry <= '0;
            res_err   <= 1'b0;
        end else begin
            if ((state == S_SRCH) && !lsu_s1_req) begin
                res_found <= s1_found;
                res_index <= s1_found ? s1_index : '0;
            end
            if (state == S_RD) begin
                res_entry <= tlb_r_entry;
            end
            if ((state != S_DONE) && (state_nxt == S_DONE)) begin
                res_err <= (state == S_IDLE) || ((state == S_INV) && inv_bad);
            end
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: a stub TLB memory plus a spec-level model of
// entries, fill victims, latencies and result registers.
module tb_tlb_op_ctrl;

    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            op_valid;
    logic            op_ready;
    logic [2:0]      op_code;
    logic [4:0]      inv_op;
    logic [9:0]      inv_asid;
    logic [18:0]     inv_vppn;
    logic [IDXW-1:0] csr_index;
    logic            csr_ne;
    logic [5:0]      csr_ps;
    logic [18:0]     csr_vppn;
    logic [9:0]      csr_asid;
    logic            csr_g;
    logic [25:0]     csr_elo0;
    logic [25:0]     csr_elo1;
    logic            csr_tlbr;
    logic            lsu_s1_req;
    logic            s1_sel;
    logic [18:0]     s1_vppn;
    logic [9:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic            tlb_we;
    logic [IDXW-1:0] tlb_w_index;
    logic [88:0]     tlb_w_entry;
    logic [IDXW-1:0] tlb_r_index;
    logic [88:0]     tlb_r_entry;
    logic            tlb_inv_valid;
    logic [4:0]      tlb_inv_op;
    logic            done;
    logic            res_found;
    logic [IDXW-1:0] res_index;
    logic [88:0]     res_entry;
    logic            res_err;

    tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .csr_index(csr_index), .csr_ne(csr_ne), .csr_ps(csr_ps), .csr_vppn(csr_vppn),
        .csr_asid(csr_asid), .csr_g(csr_g), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .csr_tlbr(csr_tlbr), .lsu_s1_req(lsu_s1_req), .s1_sel(s1_sel), .s1_vppn(s1_vppn),
        .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index), .tlb_we(tlb_we),
        .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry), .tlb_r_index(tlb_r_index),
        .tlb_r_entry(tlb_r_entry), .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op),
        .done(done), .res_found(res_found), .res_index(res_index), .res_entry(res_entry),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Stub TLB storage; expectations come from exp_mem, never from this array.
    logic [88:0] tlb_mem [TLBNUM];
    logic [88:0] exp_mem [TLBNUM];
    initial begin
        for (int i = 0; i < TLBNUM; i++) begin
            tlb_mem[i] = '0;
            exp_mem[i] = '0;
        end
    end
    always @(posedge clk) if (tlb_we) tlb_mem[tlb_w_index] <= tlb_w_entry;
    assign tlb_r_entry = tlb_mem[tlb_r_index];

    int errors = 0;
    int checks = 0;

    int              model_fill;
    logic            exp_found;
    logic [IDXW-1:0] exp_index;

    int              n_we, n_inv, n_sel, sel_in_stall, overlap;
    logic [IDXW-1:0] rec_w_index, rec_r_index;
    logic [88:0]     rec_w_entry;
    logic [4:0]      rec_inv_op;
    logic [18:0]     rec_s1_vppn;
    logic [9:0]      rec_s1_asid;
    logic            rec_done_after;

    function automatic logic [88:0] mk_entry(input logic e, input logic [18:0] v, input logic [5:0] ps,
                                             input logic [9:0] a, input logic g,
                                             input logic [25:0] l0, input logic [25:0] l1);
        return {e, v, ps, a, g, l0, l1};
    endfunction

    function automatic int fill_expected_index(input int m);
`ifdef TLB_FILL_LFSR_EN
        return m % TLBNUM;
`else
        return m;
`endif
    endfunction

    task automatic fill_model_reset();
`ifdef TLB_FILL_LFSR_EN
        model_fill = 1;
`else
        model_fill = 0;
`endif
    endtask

    task automatic fill_model_advance();
`ifdef TLB_FILL_LFSR_EN
        logic [7:0] l;
        l = 8'(model_fill);
        l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        model_fill = int'(l);
`else
        model_fill = (model_fill + 1) % TLBNUM;
`endif
    endtask

    task automatic randomize_csrs();
        csr_index = IDXW'($urandom_range(0, TLBNUM - 1));
        csr_ne    = 1'($urandom);
        csr_ps    = 6'($urandom);
        csr_vppn  = 19'($urandom);
        csr_asid  = 10'($urandom);
        csr_g     = 1'($urandom);
        csr_elo0  = 26'($urandom);
        csr_elo1  = 26'($urandom);
        csr_tlbr  = 1'($urandom);
    endtask

    // Issues one op (entered and left at posedge+1), scrambles operands after acceptance,
    // holds the LSU off port 1 for 'stall' cycles and records what the DUT did.
    task automatic run_op(input logic [2:0] code, input int stall, output int lat);
        op_valid = 1'b1;
        op_code  = code;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_code  = 3'($urandom);
        randomize_csrs();
        inv_op   = 5'($urandom);
        inv_asid = 10'($urandom);
        inv_vppn = 19'($urandom);
        n_we = 0; n_inv = 0; n_sel = 0; sel_in_stall = 0; overlap = 0;
        rec_r_index = '0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            lsu_s1_req = (i <= stall);
            #1;
            if (tlb_we) begin n_we++; rec_w_index = tlb_w_index; rec_w_entry = tlb_w_entry; end
            if (tlb_inv_valid) begin n_inv++; rec_inv_op = tlb_inv_op; end
            if (s1_sel) begin
                n_sel++;
                rec_s1_vppn = s1_vppn;
                rec_s1_asid = s1_asid;
                if (lsu_s1_req) sel_in_stall++;
            end
            if (tlb_we && tlb_inv_valid) overlap++;
            if (i == 1) rec_r_index = tlb_r_index;
            if (done) begin lat = i; break; end
            @(posedge clk); #1;
        end
        lsu_s1_req = 1'b0;
        @(posedge clk); #1;
        rec_done_after = done;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        op_valid = 0; op_code = 0; inv_op = 0; inv_asid = 0; inv_vppn = 0;
        csr_index = 0; csr_ne = 0; csr_ps = 0; csr_vppn = 0; csr_asid = 0; csr_g = 0;
        csr_elo0 = 0; csr_elo1 = 0; csr_tlbr = 0; lsu_s1_req = 0; s1_found = 0; s1_index = 0;
        fill_model_reset();
        exp_found = 1'b0;
        exp_index = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_op_ready got=%b exp=1", op_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if ({s1_sel, tlb_we, tlb_inv_valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_strobes got=%b exp=000", {s1_sel, tlb_we, tlb_inv_valid}); end
        checks++; if ({res_found, res_index, res_err} !== '0) begin errors++; $display("[TB] FAIL reset_res got=%b/%0d/%b exp=0", res_found, res_index, res_err); end
        checks++; if (res_entry !== 89'd0) begin errors++; $display("[TB] FAIL reset_res_entry got=%h exp=0", res_entry); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        int lat;
        logic [88:0] exp;
        int idx;
        for (int k = 0; k < 17; k++) begin
            randomize_csrs();
            csr_vppn = 19'h1;
            csr_ne   = 1'b0;
            exp = mk_entry(1'b1, csr_vppn, csr_ps, csr_asid, csr_g, csr_elo0, csr_elo1);
            idx = fill_expected_index(model_fill);
            run_op(3'd3, 0, lat);
            checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL fill_latency k=%0d got=%0d exp=2", k, lat); end
            checks++; if (n_we !== 1) begin errors++; $display("[TB] FAIL fill_we_count k=%0d got=%0d exp=1", k, n_we); end
            checks++; if (rec_w_index !== IDXW'(idx)) begin errors++; $display("[TB] FAIL fill_index k=%0d got=%0d exp=%0d", k, rec_w_index, idx); end
            checks++; if (rec_w_entry !== exp) begin errors++; $display("[TB] FAIL fill_entry k=%0d got=%h exp=%h", k, rec_w_entry, exp); end
            exp_mem[idx] = exp;
            fill_model_advance();
        end
    endtask

    task automatic test_wr_rd();
        int lat;
        logic [88:0] exp;
        int j;
        for (int k = 0; k < 8; k++) begin
            randomize_csrs();
            if (k == 0) begin csr_index = 5; csr_ne = 1; csr_tlbr = 0; end
            if (k == 1) begin csr_index = 5; csr_ne = 1; csr_tlbr = 1; end
            exp = mk_entry(csr_tlbr | ~csr_ne, csr_vppn, csr_ps, csr_asid, csr_g, csr_elo0, csr_elo1);
            j = int'(csr_index);
            run_op(3'd2, 0, lat);
            checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL wr_latency k=%0d got=%0d exp=2", k, lat); end
            checks++; if (n_we !== 1 || rec_w_index !== IDXW'(j)) begin errors++; $display("[TB] FAIL wr_index k=%0d got=%0d/%0d exp=1/%0d", k, n_we, rec_w_index, j); end
            checks++; if (rec_w_entry !== exp) begin errors++; $display("[TB] FAIL wr_entry k=%0d got=%h exp=%h", k, rec_w_entry, exp); end
            exp_mem[j] = exp;
            if (k >= 2) j = $urandom_range(0, TLBNUM - 1);
            randomize_csrs();
            csr_index = IDXW'(j);
            run_op(3'd1, 0, lat);
            checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL rd_latency k=%0d got=%0d exp=2", k, lat); end
            checks++; if (rec_r_index !== IDXW'(j) || n_we !== 0) begin errors++; $display("[TB] FAIL rd_index k=%0d got=%0d exp=%0d", k, rec_r_index, j); end
            checks++; if (res_entry !== exp_mem[j]) begin errors++; $display("[TB] FAIL rd_entry k=%0d got=%h exp=%h", k, res_entry, exp_mem[j]); end
            if (k < 2) begin
                checks++; if (res_entry[88] !== logic'(k)) begin errors++; $display("[TB] FAIL rd_e_bit k=%0d got=%b exp=%0d", k, res_entry[88], k); end
            end
        end
    endtask

    task automatic test_srch();
        int lat, stall;
        logic [18:0] v;
        logic [9:0]  a;
        for (int k = 0; k < 6; k++) begin
            randomize_csrs();
            v = csr_vppn;
            a = csr_asid;
            stall    = (k == 0) ? 3 : $urandom_range(0, 4);
            s1_found = (k == 0) ? 1'b1 : 1'($urandom);
            s1_index = IDXW'($urandom);
            exp_found = s1_found;
            exp_index = s1_found ? s1_index : '0;
            run_op(3'd0, stall, lat);
            checks++; if (lat !== 2 + stall) begin errors++; $display("[TB] FAIL srch_latency k=%0d got=%0d exp=%0d", k, lat, 2 + stall); end
            checks++; if (sel_in_stall !== 0 || n_sel !== 1) begin errors++; $display("[TB] FAIL srch_sel k=%0d got=%0d/%0d exp=0/1", k, sel_in_stall, n_sel); end
            checks++; if (rec_s1_vppn !== v || rec_s1_asid !== a) begin errors++; $display("[TB] FAIL srch_key k=%0d got=%h/%h exp=%h/%h", k, rec_s1_vppn, rec_s1_asid, v, a); end
            checks++; if (res_found !== exp_found || res_index !== exp_index) begin errors++; $display("[TB] FAIL srch_result k=%0d got=%b/%0d exp=%b/%0d", k, res_found, res_index, exp_found, exp_index); end
            checks++; if (n_we !== 0 || n_inv !== 0 || res_err !== 1'b0) begin errors++; $display("[TB] FAIL srch_side k=%0d got=%0d/%0d/%b exp=0/0/0", k, n_we, n_inv, res_err); end
        end
        s1_found = 1'b0;
    endtask

    task automatic test_inv();
        int lat, stall;
        logic [4:0]  op;
        logic [9:0]  a;
        logic [18:0] v;
        for (int k = 0; k < 6; k++) begin
            op    = (k == 0) ? 5'd5 : 5'($urandom_range(0, 6));
            a     = (k == 0) ? 10'h3 : 10'($urandom);
            v     = (k == 0) ? 19'h40 : 19'($urandom);
            stall = (k == 0) ? 2 : $urandom_range(0, 3);
            inv_op = op; inv_asid = a; inv_vppn = v;
            run_op(3'd4, stall, lat);
            checks++; if (lat !== 2 + stall) begin errors++; $display("[TB] FAIL inv_latency k=%0d got=%0d exp=%0d", k, lat, 2 + stall); end
            checks++; if (n_inv !== 1 || n_sel !== 1 || sel_in_stall !== 0) begin errors++; $display("[TB] FAIL inv_strobe k=%0d got=%0d/%0d/%0d exp=1/1/0", k, n_inv, n_sel, sel_in_stall); end
            checks++; if (rec_inv_op !== op || rec_s1_asid !== a || rec_s1_vppn !== v) begin errors++; $display("[TB] FAIL inv_operands k=%0d got=%0d/%h/%h exp=%0d/%h/%h", k, rec_inv_op, rec_s1_asid, rec_s1_vppn, op, a, v); end
            checks++; if (res_err !== 1'b0 || res_found !== exp_found || res_index !== exp_index) begin errors++; $display("[TB] FAIL inv_res_hold k=%0d got=%b/%b/%0d exp=0/%b/%0d", k, res_err, res_found, res_index, exp_found, exp_index); end
        end
        inv_op = 5'd9; inv_asid = 10'h3; inv_vppn = 19'h40;
        run_op(3'd4, 2, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL inv_bad_latency got=%0d exp=2", lat); end
        checks++; if (n_inv !== 0 || n_sel !== 0) begin errors++; $display("[TB] FAIL inv_bad_strobe got=%0d/%0d exp=0/0", n_inv, n_sel); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("[TB] FAIL inv_bad_err got=%b exp=1", res_err); end
    endtask

    task automatic test_illegal();
        int lat;
        for (int c = 6; c <= 7; c++) begin
            run_op(3'(c), 0, lat);
            checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL illegal_latency code=%0d got=%0d exp=1", c, lat); end
            checks++; if (res_err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err code=%0d got=%b exp=1", c, res_err); end
            checks++; if (n_we !== 0 || n_inv !== 0 || n_sel !== 0) begin errors++; $display("[TB] FAIL illegal_strobes code=%0d got=%0d/%0d/%0d exp=0", c, n_we, n_inv, n_sel); end
            checks++; if (rec_done_after !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width code=%0d got=%b exp=0", c, rec_done_after); end
        end
        csr_index = 5;
        run_op(3'd1, 0, lat);
        checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared got=%b exp=0", res_err); end
    endtask

    task automatic test_reset_mid();
        int lat, idx;
        logic [88:0] exp;
        op_valid = 1'b1; op_code = 3'd0;
        @(posedge clk); #1;
        op_valid = 1'b0; lsu_s1_req = 1'b1;
        @(posedge clk); #1;
        checks++; if (op_ready !== 1'b0 || s1_sel !== 1'b0) begin errors++; $display("[TB] FAIL stall_state got=%b/%b exp=0/0", op_ready, s1_sel); end
        resetn = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1 || s1_sel !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_srch got=%b/%b/%b exp=1/0/0", op_ready, s1_sel, done); end
        checks++; if (res_entry !== 89'd0 || res_found !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_res got=%h/%b exp=0/0", res_entry, res_found); end
        fill_model_reset();
        exp_found = 1'b0; exp_index = '0;
        #2 resetn = 1'b1;
        lsu_s1_req = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = 3'd2;
        @(posedge clk); #1;
        op_valid = 1'b0;
        checks++; if (tlb_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_strobe_before_reset got=%b exp=1", tlb_we); end
        resetn = 1'b0;
        #1;
        checks++; if (tlb_we !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_wr got=%b/%b exp=0/1", tlb_we, op_ready); end
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        randomize_csrs();
        csr_ne = 1'b0;
        exp = mk_entry(1'b1, csr_vppn, csr_ps, csr_asid, csr_g, csr_elo0, csr_elo1);
        idx = fill_expected_index(model_fill);
        run_op(3'd3, 0, lat);
        checks++; if (lat !== 2 || n_we !== 1) begin errors++; $display("[TB] FAIL post_reset_fill got=%0d/%0d exp=2/1", lat, n_we); end
        checks++; if (rec_w_index !== IDXW'(idx) || rec_w_entry !== exp) begin errors++; $display("[TB] FAIL post_reset_fill_index got=%0d exp=%0d", rec_w_index, idx); end
        exp_mem[idx] = exp;
        fill_model_advance();
    endtask

    initial begin
        int total_overlap;
        total_overlap = 0;
        test_reset();
        test_fill();
        total_overlap += overlap;
        test_wr_rd();
        total_overlap += overlap;
        test_srch();
        test_inv();
        total_overlap += overlap;
        test_illegal();
        test_reset_mid();
        checks++; if (total_overlap !== 0) begin errors++; $display("[TB] FAIL we_inv_overlap got=%0d exp=0", total_overlap); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
